bit_serial_alu: RTL and testbench

- Multi-bit ALU front-end that runs a WIDTH-bit operation one bit per cycle through a single one-bit ALU slice.
- Operands are processed LSB-first; carry is held in a register between bits, and the result and flags are assembled into parallel outputs.
- Sits between the operand/decode logic and the register write-back.
- A start/ready/done handshake sequences it; it is the area-minimal execute stage for the RISC-V datapath.

---
 rtl/alu_pkg.sv | 8 +
 rtl/alu_bit_slice.sv | 23 ++
 rtl/bit_serial_alu.sv | 89 ++++++++
 tb/tb_bit_serial_alu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings and FSM state type shared by the bit-serial ALU.
package alu_pkg;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational one-bit ALU with operand inversion and full-adder carry.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);
    logic x, y;
    always_comb begin
        x = a ^ a_invert;
        y = b ^ b_invert;
        result = operation == OP_AND ? x & y :
                 operation == OP_OR  ? x | y :
                 operation == OP_XOR ? x ^ y : x ^ y ^ carry_in;
        carry_out = (x & y) | (carry_in & (x ^ y));
    end
endmodule

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: WIDTH-bit ALU executed LSB-first through one bit slice, start/ready/done handshake.
// Defining BIT_SERIAL_ALU_OVF_EN adds the signed overflow output and its MSB carry-in capture.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic             carry_in,
    input  logic [1:0]       operation,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             carry_out
`ifdef BIT_SERIAL_ALU_OVF_EN
    ,output logic            overflow
`endif
);
    localparam int CW = $clog2(WIDTH);
    state_t state, next_state;
    logic [WIDTH-1:0] sa, sb, shift;
    logic [CW-1:0] cnt;
    logic [1:0] op;
    logic ai, bi, carry, acc, accept, last, slice_r, slice_c, carry_next;
    alu_bit_slice u_slice (
        .a(sa[0]), .b(sb[0]), .a_invert(ai), .b_invert(bi), .carry_in(carry),
        .operation(op), .result(slice_r), .carry_out(slice_c)
    );
    always_comb begin
        ready = state != RUN;
        done = state == DONE;
        accept = ready & start;
        last = cnt == CW'(WIDTH - 1);
        carry_next = op == OP_ADD ? slice_c : 1'b0;
        next_state = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) state <= !reset_n ? IDLE : next_state;
    // Shift state runs independently; the visible outputs load only on the final bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sa <= '0;
            sb <= '0;
            shift <= '0;
            ai <= 1'b0;
            bi <= 1'b0;
            op <= OP_AND;
            carry <= 1'b0;
            acc <= 1'b0;
            cnt <= '0;
            result <= '0;
            zf <= 1'b1;
            carry_out <= 1'b0;
`ifdef BIT_SERIAL_ALU_OVF_EN
            overflow <= 1'b0;
`endif
        end else if (accept) begin
            sa <= a;
            sb <= b;
            ai <= a_invert;
            bi <= b_invert;
            op <= operation;
            carry <= operation == OP_ADD ? carry_in : 1'b0;
            acc <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            shift <= {slice_r, shift[WIDTH-1:1]};
            carry <= carry_next;
            acc <= acc | slice_r;
            cnt <= cnt + 1'b1;
            if (last) begin
                result <= {slice_r, shift[WIDTH-1:1]};
                zf <= ~(acc | slice_r);
                carry_out <= carry_next;
`ifdef BIT_SERIAL_ALU_OVF_EN
                overflow <= op == OP_ADD ? carry ^ slice_c : 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: randomized and directed checks of bit_serial_alu against a cycle-count reference model.
// Overflow is checked only when BIT_SERIAL_ALU_OVF_EN is defined.
module tb_bit_serial_alu;
    localparam int WIDTH = 32;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic a_invert = 1'b0, b_invert = 1'b0, carry_in = 1'b0;
    logic [1:0] operation = 2'b00;
    logic ready, done, zf, carry_out;
    logic [WIDTH-1:0] result;
`ifdef BIT_SERIAL_ALU_OVF_EN
    logic overflow;
`endif
    int errors = 0, checks = 0;

    bit_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .a_invert(a_invert), .b_invert(b_invert), .carry_in(carry_in), .operation(operation),
        .ready(ready), .done(done), .result(result), .zf(zf), .carry_out(carry_out)
`ifdef BIT_SERIAL_ALU_OVF_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the inverted operands, returns {overflow, carry, result}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic xi, input logic yi, input logic ci,
                                          input logic [1:0] o);
        logic [31:0] p, q, r;
        logic [32:0] s;
        logic cy, ov;
        p = xi ? ~x : x;
        q = yi ? ~y : y;
        s = {1'b0, p} + {1'b0, q} + {32'd0, ci};
        cy = 1'b0;
        ov = 1'b0;
        case (o)
            2'b00: r = p & q;
            2'b01: r = p | q;
            2'b10: r = p ^ q;
            default: begin
                r = s[31:0];
                cy = s[32];
                ov = (p[31] == q[31]) && (r[31] != p[31]);
            end
        endcase
        return {ov, cy, r};
    endfunction

    int m_left = 0;
    logic m_done = 1'b0, m_zf = 1'b1, m_cy = 1'b0, m_ov = 1'b0;
    logic [31:0] m_res = '0;
    logic [33:0] pend = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_left <= 0; m_done <= 1'b0; m_res <= '0; m_zf <= 1'b1; m_cy <= 1'b0; m_ov <= 1'b0;
        end else if (m_left == 0 && start) begin
            pend <= model(a, b, a_invert, b_invert, carry_in, operation);
            m_left <= WIDTH;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= m_left == 1;
            if (m_left == 1) begin
                m_res <= pend[31:0];
                m_zf <= pend[31:0] == 32'd0;
                m_cy <= pend[32];
                m_ov <= pend[33];
            end
        end else
            m_done <= 1'b0;
    end

    always @(negedge clk) begin
        chk("ready", ready, m_left == 0);
        chk("done", done, m_done);
        chk("result", result, m_res);
        chk("zf", zf, m_zf);
        chk("carry_out", carry_out, m_cy);
`ifdef BIT_SERIAL_ALU_OVF_EN
        chk("overflow", overflow, m_ov);
`endif
    end

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iai, input logic ibi,
                         input logic icin, input logic [1:0] iop, input bit noise);
        int n;
        a = ia; b = ib; a_invert = iai; b_invert = ibi; carry_in = icin; operation = iop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < WIDTH + 8) begin
            if (noise && n == 10) begin
                start = 1'b1; a = $urandom; b = $urandom; operation = 2'($urandom);
            end else
                start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", n, WIDTH);
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic iai, input logic ibi,
                          input logic icin, input logic [1:0] iop, input bit noise);
        @(negedge clk);
        issue(ia, ib, iai, ibi, icin, iop, noise);
    endtask

    task automatic expect_out(input string name, input logic [31:0] r, input logic z, input logic c,
                              input logic v);
        chk({name, "_result"}, result, r);
        chk({name, "_zf"}, zf, z);
        chk({name, "_carry"}, carry_out, c);
`ifdef BIT_SERIAL_ALU_OVF_EN
        chk({name, "_ovf"}, overflow, v);
`else
        if (v && !v) chk("unused", 0, 0);
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_result", result, 0);
        chk("rst_zf", zf, 1);
        reset_n = 1'b1;
        run_op(32'd5, 32'd7, 0, 0, 0, 2'b11, 0);
        expect_out("add", 32'd12, 0, 0, 0);
        run_op(32'd5, 32'd5, 0, 1, 1, 2'b11, 0);
        expect_out("sub", 32'd0, 1, 1, 0);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 2'b00, 0);
        expect_out("and", 32'hF000F000, 0, 0, 0);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 2'b01, 0);
        expect_out("or", 32'hFFF0FFF0, 0, 0, 0);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 2'b10, 0);
        expect_out("xor", 32'h0FF00FF0, 0, 0, 0);
        run_op(32'hFFFFFFFF, 32'd1, 0, 0, 0, 2'b11, 0);
        expect_out("wrap", 32'd0, 1, 1, 0);
        run_op(32'h7FFFFFFF, 32'd1, 0, 0, 0, 2'b11, 0);
        expect_out("ovf", 32'h80000000, 0, 0, 1);
        run_op(32'd5, 32'd7, 0, 0, 0, 2'b11, 1);
        expect_out("ignore", 32'd12, 0, 0, 0);
        chk("b2b_ready", ready, 1);
        issue(32'd100, 32'd23, 0, 0, 0, 2'b11, 0);
        expect_out("b2b", 32'd123, 0, 0, 0);
        @(negedge clk);
        a = 32'd9; b = 32'd9; operation = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_zf", zf, 1);
        seen = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_op(32'h1234, 32'h00FF, 0, 0, 0, 2'b10, 0);
        expect_out("post", 32'h12CB, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1)
                issue(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                      $urandom_range(0, 3) == 0);
            else
                run_op(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                       $urandom_range(0, 3) == 0);
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
